// File: rtl/fw_pkg.sv
// Shared encodings for the firewall event scheduler and the firewall core.
package fw_pkg;

    typedef enum logic [1:0] {
        SCHED_ACTIVE   = 2'd0,
        SCHED_BLOCKED  = 2'd1,
        SCHED_COOLDOWN = 2'd2
    } sched_state_e;

    typedef enum logic {
        EV_RULE    = 1'b0,
        EV_PATTERN = 1'b1
    } ev_type_e;

    typedef enum logic [1:0] {
        FW_IDLE    = 2'd0,
        FW_MONITOR = 2'd1,
        FW_BLOCK   = 2'd2,
        FW_RECOVER = 2'd3
    } fw_state_e;

    localparam int GRANT_ID_W = 3;

endpackage

// File: rtl/fw_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr_i wins.
module fw_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        logic [IW-1:0] j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/fw_event_scheduler.sv
// Round-robin scheduler of detector violation events into the firewall FSM.
// Optional per-source strike masking is enabled with `define SCHED_SRC_MASK_EN.
module fw_event_scheduler
    import fw_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int CNT_W      = 8,
    parameter int COOLDOWN   = 8,
    parameter int STRIKE_MAX = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    req_valid,
    input  logic [NUM_SRC-1:0]    req_type,
    output logic [NUM_SRC-1:0]    req_ready,
    input  logic                  fw_block,
    input  logic                  mask_clr,
    output logic                  rule_violation,
    output logic                  pattern_violation,
    output logic [GRANT_ID_W-1:0] grant_id,
    output logic [NUM_SRC-1:0]    src_mask,
    output logic [CNT_W-1:0]      event_count,
    output logic [CNT_W-1:0]      drop_count
);

    localparam int PTR_W = $clog2(NUM_SRC);
    localparam int CD_W  = $clog2(COOLDOWN + 1);

    sched_state_e          state_q;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CD_W-1:0]       cd_q;
    logic                  rule_q, pat_q;
    logic [GRANT_ID_W-1:0] gid_q;
    logic [CNT_W-1:0]      ev_q, ev_d, dr_q, dr_d;
    logic [NUM_SRC-1:0]    mask_q;

    logic [NUM_SRC-1:0]    arb_gnt;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  xfer, fwd, blk_drop, mdrop;
    logic [CNT_W:0]        dr_sum;

    fw_rr_arbiter #(.N(NUM_SRC)) u_arb (
        .req_i (req_valid & ~mask_q),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    assign xfer     = arb_any && (state_q != SCHED_COOLDOWN);
    assign fwd      = xfer && (state_q == SCHED_ACTIVE);
    assign blk_drop = xfer && (state_q == SCHED_BLOCKED);

    // Masked sources are always drained so a misbehaving detector never stalls.
    assign req_ready = (xfer ? arb_gnt : '0) | (req_valid & mask_q);

    assign ptr_d  = (arb_idx == PTR_W'(NUM_SRC - 1)) ? '0 : arb_idx + PTR_W'(1);
    assign ev_d   = (ev_q == '1) ? ev_q : ev_q + CNT_W'(1);
    assign dr_sum = {1'b0, dr_q} + (CNT_W+1)'(blk_drop) + (CNT_W+1)'(mdrop);
    assign dr_d   = dr_sum[CNT_W] ? '1 : dr_sum[CNT_W-1:0];

`ifdef SCHED_SRC_MASK_EN
    localparam int SW = $clog2(STRIKE_MAX + 1);
    logic [NUM_SRC-1:0][SW-1:0] strike_q;

    assign mdrop = |(req_valid & mask_q);

    // Mask is set on the same edge as the final strike so the next event is dropped.
    always_ff @(posedge clk) begin
        if (rst || mask_clr) begin
            strike_q <= '0;
            mask_q   <= '0;
        end else if (fwd) begin
            strike_q[arb_idx] <= strike_q[arb_idx] + SW'(1);
            if (strike_q[arb_idx] == SW'(STRIKE_MAX - 1))
                mask_q[arb_idx] <= 1'b1;
        end
    end
`else
    logic unused_mask_clr;
    assign unused_mask_clr = mask_clr;
    assign mask_q          = '0;
    assign mdrop           = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCHED_ACTIVE;
            ptr_q   <= '0;
            cd_q    <= '0;
            rule_q  <= 1'b0;
            pat_q   <= 1'b0;
            gid_q   <= '0;
            ev_q    <= '0;
            dr_q    <= '0;
        end else begin
            rule_q <= fwd && (req_type[arb_idx] == EV_RULE);
            pat_q  <= fwd && (req_type[arb_idx] == EV_PATTERN);
            dr_q   <= dr_d;
            if (xfer) ptr_q <= ptr_d;
            if (fwd) begin
                gid_q <= GRANT_ID_W'(arb_idx);
                ev_q  <= ev_d;
            end
            case (state_q)
                SCHED_ACTIVE:
                    if (fw_block) state_q <= SCHED_BLOCKED;
                SCHED_BLOCKED:
                    if (!fw_block) begin
                        state_q <= SCHED_COOLDOWN;
                        cd_q    <= CD_W'(COOLDOWN - 1);
                    end
                SCHED_COOLDOWN:
                    if (fw_block)         state_q <= SCHED_BLOCKED;
                    else if (cd_q == '0)  state_q <= SCHED_ACTIVE;
                    else                  cd_q    <= cd_q - CD_W'(1);
                default:
                    state_q <= SCHED_ACTIVE;
            endcase
        end
    end

    assign rule_violation    = rule_q;
    assign pattern_violation = pat_q;
    assign grant_id          = gid_q;
    assign event_count       = ev_q;
    assign drop_count        = dr_q;
    assign src_mask          = mask_q;

endmodule

// File: tb/tb_fw_event_scheduler.sv
// Self-checking bench for fw_event_scheduler: directed scenarios plus random traffic vs a reference model.
module tb_fw_event_scheduler;
    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int CD   = 8;
    localparam int SM   = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, fw_block, mask_clr;
    logic [N-1:0]  req_valid, req_type, req_ready, src_mask;
    logic          rule_violation, pattern_violation;
    logic [2:0]    grant_id;
    logic [CW-1:0] event_count, drop_count;

    always #5 clk = ~clk;

    fw_event_scheduler #(.NUM_SRC(N), .CNT_W(CW), .COOLDOWN(CD), .STRIKE_MAX(SM)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_type(req_type), .req_ready(req_ready),
        .fw_block(fw_block), .mask_clr(mask_clr), .rule_violation(rule_violation),
        .pattern_violation(pattern_violation), .grant_id(grant_id), .src_mask(src_mask),
        .event_count(event_count), .drop_count(drop_count)
    );

    int ntests = 0, nfail = 0;

    // Reference model: 0 = forwarding, 1 = blocked (draining), 2 = quiet cooldown
    int       m_mode, m_cd, m_ptr, m_gid, m_ev, m_dr;
    bit       m_rule, m_pat;
    int       m_strike[N];
    bit [N-1:0] m_mask;
    logic [N-1:0] obs_rdy, exp_rdy;

    function automatic int pick_winner();
        if (m_mode == 2) return -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j] && !m_mask[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        int w, inc;
        #1;
        w       = pick_winner();
        exp_rdy = req_valid & m_mask;
        if (w >= 0) exp_rdy[w] = 1'b1;
        obs_rdy = req_ready;
        @(posedge clk);
        if (rst) begin
            m_mode = 0; m_cd = 0; m_ptr = 0; m_gid = 0; m_ev = 0; m_dr = 0;
            m_rule = 0; m_pat = 0; m_mask = '0;
            for (int i = 0; i < N; i++) m_strike[i] = 0;
        end else begin
            m_rule = 0; m_pat = 0;
            inc = (|(req_valid & m_mask)) ? 1 : 0;
            if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (m_mode == 0) begin
                    if (req_type[w]) m_pat = 1; else m_rule = 1;
                    m_gid = w;
                    m_ev  = (m_ev < MAXC) ? m_ev + 1 : MAXC;
                    m_strike[w]++;
                end else inc++;
            end
            m_dr = (m_dr + inc > MAXC) ? MAXC : m_dr + inc;
`ifdef SCHED_SRC_MASK_EN
            if (mask_clr) begin
                m_mask = '0;
                for (int i = 0; i < N; i++) m_strike[i] = 0;
            end else
                for (int i = 0; i < N; i++) if (m_strike[i] >= SM) m_mask[i] = 1'b1;
`endif
            case (m_mode)
                0: if (fw_block) m_mode = 1;
                1: if (!fw_block) begin m_mode = 2; m_cd = CD - 1; end
                default: if (fw_block) m_mode = 1;
                         else if (m_cd == 0) m_mode = 0;
                         else m_cd--;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; req_valid = '0; req_type = '0; fw_block = 0; mask_clr = 0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        ntests++;
        if ({rule_violation, pattern_violation, grant_id, event_count, drop_count, src_mask} !== '0) begin
            nfail++;
            $display("FAIL reset_outputs got rv=%b pv=%b gid=%0d ev=%0d dr=%0d mask=%b want all 0",
                     rule_violation, pattern_violation, grant_id, event_count, drop_count, src_mask);
        end
        ntests++;
        if (obs_rdy !== '0) begin nfail++; $display("FAIL reset_idle_ready got %b want 0000", obs_rdy); end
        req_valid = 4'b1111;
        tick();
        ntests++;
        if (obs_rdy !== 4'b0001) begin nfail++; $display("FAIL reset_ptr_zero got %b want 0001", obs_rdy); end
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 4'b0001; req_type = 4'b0000;
        tick();
        ntests++;
        if (obs_rdy !== 4'b0001) begin nfail++; $display("FAIL single_ready got %b want 0001", obs_rdy); end
        ntests++;
        if ({rule_violation, pattern_violation, event_count, grant_id} !== {1'b1, 1'b0, 8'd1, 3'd0}) begin
            nfail++;
            $display("FAIL single_pulse got rv=%b pv=%b ev=%0d gid=%0d want 1 0 1 0",
                     rule_violation, pattern_violation, event_count, grant_id);
        end
        req_valid = '0;
        tick();
        ntests++;
        if (rule_violation !== 1'b0) begin nfail++; $display("FAIL single_one_cycle got rv=%b want 0", rule_violation); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'b1111; req_type = 4'($urandom);
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] want;
            want = N'(1 << (k % N));
            tick();
            ntests++;
            if (obs_rdy !== want || grant_id !== 3'(k % N) ||
                pattern_violation !== req_type[k % N] || rule_violation !== ~req_type[k % N]) begin
                nfail++;
                $display("FAIL rr_step%0d got rdy=%b gid=%0d rv=%b pv=%b want rdy=%b gid=%0d type=%b",
                         k, obs_rdy, grant_id, rule_violation, pattern_violation, want, k % N, req_type[k % N]);
            end
        end
    endtask

    task automatic test_block_cooldown();
        bit pulsed, early;
        do_reset();
        fw_block = 1; req_valid = 4'b0100; req_type = '0;
        tick();
        ntests++;
        if (rule_violation !== 1'b1) begin nfail++; $display("FAIL block_first_fwd got rv=%b want 1", rule_violation); end
        pulsed = 0;
        for (int c = 1; c < 10; c++) begin
            tick();
            if (rule_violation || pattern_violation) pulsed = 1;
        end
        ntests++;
        if (pulsed) begin nfail++; $display("FAIL block_no_pulse got pulse want none"); end
        fw_block = 0; req_valid = '0;
        tick();
        ntests++;
        if (drop_count !== 8'd9 || event_count !== 8'd1) begin
            nfail++; $display("FAIL block_drops got dr=%0d ev=%0d want 9 1", drop_count, event_count);
        end
        req_valid = 4'b0100;
        early = 0;
        for (int c = 0; c < CD; c++) begin
            tick();
            if (obs_rdy !== '0 || rule_violation) early = 1;
        end
        ntests++;
        if (early) begin nfail++; $display("FAIL cooldown_quiet got ready/pulse during cooldown want none"); end
        tick();
        ntests++;
        if (obs_rdy !== 4'b0100 || rule_violation !== 1'b1) begin
            nfail++; $display("FAIL cooldown_exit got rdy=%b rv=%b want 0100 1", obs_rdy, rule_violation);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 4'b0010; req_type = 4'b0010; fw_block = 1;
        tick();
        ntests++;
        if ({pattern_violation, rule_violation, grant_id} !== {1'b1, 1'b0, 3'd1}) begin
            nfail++; $display("FAIL simul_fwd got pv=%b rv=%b gid=%0d want 1 0 1",
                              pattern_violation, rule_violation, grant_id);
        end
        fw_block = 0;
        tick();
        ntests++;
        if (pattern_violation !== 1'b0 || drop_count !== 8'd1 || event_count !== 8'd1 || obs_rdy !== 4'b0010) begin
            nfail++; $display("FAIL simul_blocked got pv=%b dr=%0d ev=%0d rdy=%b want 0 1 1 0010",
                              pattern_violation, drop_count, event_count, obs_rdy);
        end
    endtask

    task automatic test_mask();
        do_reset();
        req_type = '0;
        for (int e = 0; e < SM; e++) begin
            req_valid = 4'b0010; tick();
            req_valid = '0;      tick();
        end
        req_valid = 4'b0010;
        tick();
`ifdef SCHED_SRC_MASK_EN
        ntests++;
        if (src_mask !== 4'b0010 || rule_violation !== 1'b0 || drop_count !== 8'd1 ||
            event_count !== 8'(SM) || obs_rdy !== 4'b0010) begin
            nfail++; $display("FAIL mask_set got mask=%b rv=%b dr=%0d ev=%0d rdy=%b want 0010 0 1 %0d 0010",
                              src_mask, rule_violation, drop_count, event_count, obs_rdy, SM);
        end
        req_valid = '0; mask_clr = 1;
        tick();
        mask_clr = 0;
        ntests++;
        if (src_mask !== '0) begin nfail++; $display("FAIL mask_clr got %b want 0000", src_mask); end
        req_valid = 4'b0010;
        tick();
        ntests++;
        if (rule_violation !== 1'b1) begin nfail++; $display("FAIL mask_after_clr got rv=%b want 1", rule_violation); end
`else
        ntests++;
        if (src_mask !== '0 || rule_violation !== 1'b1 || drop_count !== 8'd0 || event_count !== 8'(SM + 1)) begin
            nfail++; $display("FAIL nomask got mask=%b rv=%b dr=%0d ev=%0d want 0000 1 0 %0d",
                              src_mask, rule_violation, drop_count, event_count, SM + 1);
        end
`endif
        req_valid = '0;
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 4'b1111; req_type = 4'b0101;
        for (int c = 0; c < 300; c++) tick();
        ntests++;
        if (event_count !== 8'd255) begin nfail++; $display("FAIL ev_saturate got %0d want 255", event_count); end
        rst = 1;
        tick();
        rst = 0;
        ntests++;
        if ({rule_violation, pattern_violation, grant_id, event_count, drop_count, src_mask} !== '0) begin
            nfail++; $display("FAIL midburst_reset got rv=%b pv=%b gid=%0d ev=%0d dr=%0d want all 0",
                              rule_violation, pattern_violation, grant_id, event_count, drop_count);
        end
        fw_block = 1;
        for (int c = 0; c < 300; c++) tick();
        fw_block = 0;
        ntests++;
        if (drop_count !== 8'd255 || event_count !== 8'd1) begin
            nfail++; $display("FAIL dr_saturate got dr=%0d ev=%0d want 255 1", drop_count, event_count);
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] v, t;
        do_reset();
        v = '0; t = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if (!v[i] || obs_rdy[i]) begin
                    v[i] = ($urandom_range(0, 2) != 0);
                    t[i] = 1'($urandom);
                end
            req_valid = v; req_type = t;
            if ($urandom_range(0, 15) == 0) fw_block = ~fw_block;
            rst      = ($urandom_range(0, 199) == 0);
            mask_clr = ($urandom_range(0, 59) == 0);
            tick();
            ntests++;
            if ({obs_rdy, rule_violation, pattern_violation, grant_id, event_count, drop_count, src_mask} !==
                {exp_rdy, m_rule, m_pat, 3'(m_gid), CW'(m_ev), CW'(m_dr), m_mask}) begin
                nfail++;
                $display("FAIL random cyc=%0d rdy=%b/%b rv=%b/%b pv=%b/%b gid=%0d/%0d ev=%0d/%0d dr=%0d/%0d mask=%b/%b",
                         c, obs_rdy, exp_rdy, rule_violation, m_rule, pattern_violation, m_pat,
                         grant_id, m_gid, event_count, m_ev, drop_count, m_dr, src_mask, m_mask);
            end
        end
        rst = 0; mask_clr = 0; fw_block = 0; req_valid = '0;
    endtask

    initial begin
        rst = 1; req_valid = '0; req_type = '0; fw_block = 0; mask_clr = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_block_cooldown();
        test_simultaneous();
        test_mask();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
